// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory:
// loader FSM states, frame constants and the default memory geometry.
package imem_pkg;

   localparam int IMEM_DATA_WIDTH    = 20;
   localparam int IMEM_ADDRESS_WIDTH = 8;
   localparam int IMEM_MEM_SIZE      = 256;

   localparam int         INSTR_BYTES     = 3;
   localparam logic [7:0] PAD_NIBBLE_MASK = 8'hF0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      B0     = 3'd2,
      B1     = 3'd3,
      B2     = 3'd4,
      WRITE  = 3'd5,
      CHK    = 3'd6,
      DONE   = 3'd7
   } loader_state_t;

   // Bytes arrive least significant first; only the low nibble of the third byte carries data.
   function automatic logic [IMEM_DATA_WIDTH-1:0] pack_word(
      input logic [3:0] hi,
      input logic [7:0] mid,
      input logic [7:0] lo
   );
      return {hi, mid, lo};
   endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects the first two bytes of an instruction and forms the full word with the
// third byte as it is presented, flagging a non-zero pad nibble.
module imem_word_assembler
   import imem_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 in_data,
   input  logic                       latch_b0,
   input  logic                       latch_b1,
   output logic [IMEM_DATA_WIDTH-1:0] word,
   output logic                       pad_bad
);

   logic [7:0] b0_q;
   logic [7:0] b1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b0_q <= 8'h00;
         b1_q <= 8'h00;
      end else begin
         if (latch_b0) b0_q <= in_data;
         if (latch_b1) b1_q <= in_data;
      end
   end

   // in_data is the third byte here; the caller only uses word/pad_bad while in B2.
   assign word    = pack_word(in_data[3:0], b1_q, b0_q);
   assign pad_bad = (in_data & PAD_NIBBLE_MASK) != 8'h00;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream programmer for the 20-bit instruction memory.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH    = IMEM_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = IMEM_ADDRESS_WIDTH,
   parameter int MEM_SIZE      = IMEM_MEM_SIZE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     wr_en,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   // Valid/ready: a byte moves on a rising clk edge when in_valid && in_ready.
   // in_ready depends on state only; upstream must hold in_data until accepted.

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_SIZE - 1);

   loader_state_t             state;
   logic [7:0]                count;
   logic                      accept;
   logic                      last_word;
   logic [IMEM_DATA_WIDTH-1:0] word;
   logic                      pad_bad;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   always_comb begin
      in_ready = 1'b0;
      case (state)
         HEADER, B0, B1, B2, CHK: in_ready = 1'b1;
         default:                 in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   // The address doubles as the word index; the MEM_SIZE bound keeps it from wrapping.
   assign last_word = (wr_addr == ADDRESS_WIDTH'(count)) || (wr_addr == LAST_ADDR);

   imem_word_assembler u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .latch_b0 (accept && (state == B0)),
      .latch_b1 (accept && (state == B1)),
      .word     (word),
      .pad_bad  (pad_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= 8'h00;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cpu_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum     <= 8'h00;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= HEADER;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  wr_addr  <= '0;
               end
            end

            HEADER: begin
               if (accept) begin
                  count <= in_data;
                  state <= B0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum  <= in_data;
`endif
               end
            end

            B0, B1: begin
               if (accept) begin
                  state <= (state == B0) ? B1 : B2;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum  <= csum ^ in_data;
`endif
               end
            end

            B2: begin
               if (accept) begin
                  if (pad_bad) begin
                     error    <= 1'b1;
                     done     <= 1'b0;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     state    <= DONE;
                  end else begin
                     wr_data <= DATA_WIDTH'(word);
                     wr_en   <= 1'b1;
                     state   <= WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum    <= csum ^ in_data;
`endif
                  end
               end
            end

            WRITE: begin
               if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state    <= CHK;
`else
                  state    <= DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  wr_addr <= wr_addr + 1'b1;
                  state   <= B0;
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  if (in_data == csum) begin
                     done <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, pad error, mid-load reset, full 256-word frame.
module tb_imem_loader;
   import imem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [19:0] wr_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   int vectors = 0;
   int fails   = 0;
   logic [7:0] tb_xor;
   logic [27:0] exp_q[$];
   logic [27:0] obs_q[$];

   imem_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // write monitor: log every strobe; in_ready must be low in WRITE
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         obs_q.push_back({wr_addr, wr_data});
         check("ready_in_write", {31'b0, in_ready}, 32'h0);
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, {31'b0, in_ready}, 0);
      check({tag, "_wr_en"},    {31'b0, wr_en},    0);
      check({tag, "_wr_addr"},  {24'b0, wr_addr},  0);
      check({tag, "_wr_data"},  {12'b0, wr_data},  0);
      check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 0);
      check({tag, "_busy"},     {31'b0, busy},     0);
      check({tag, "_done"},     {31'b0, done},     0);
      check({tag, "_error"},    {31'b0, error},    0);
   endtask

   task automatic check_flags(input string tag, input logic d, input logic e, input logic b);
      check({tag, "_done"},     {31'b0, done},     {31'b0, d});
      check({tag, "_error"},    {31'b0, error},    {31'b0, e});
      check({tag, "_busy"},     {31'b0, busy},     {31'b0, b});
      check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, b});
   endtask

   // scoreboard: compare logged writes against the expected queue, then clear both
   task automatic check_writes(input string tag);
      int n;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_write"}, {4'b0, obs_q[i]}, {4'b0, exp_q[i]});
      obs_q.delete();
      exp_q.delete();
   endtask

   // drivers: called #1 after a posedge; return #1 after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int t;
      logic acc;
      t = 0;
      acc = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      while (!acc && t < 50) begin
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) check("byte_timeout", 32'h0, 32'h1);
      tb_xor = tb_xor ^ b;
   endtask

   task automatic send_gap(input logic [7:0] b);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      send_byte(b);
   endtask

   task automatic send_word(input logic [19:0] w, input logic gap);
      logic [7:0] bytes_v[3];
      bytes_v[0] = w[7:0];
      bytes_v[1] = w[15:8];
      bytes_v[2] = {4'h0, w[19:16]};
      for (int i = 0; i < 3; i++) begin
         if (gap) send_gap(bytes_v[i]);
         else     send_byte(bytes_v[i]);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      tb_xor = 8'h00;
   endtask

   // after the last B2 edge: one WRITE cycle, plus the trailer when checksumming
   task automatic finish_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = tb_xor;
      send_byte(x);
`else
      @(posedge clk);
      #1;
`endif
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tb_xor   = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      check("reset_state", 32'(dut.state), 32'(IDLE));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle("idle");

      // single-word frame 00 34 12 05
      pulse_start();
      check_flags("t1_start", 1'b0, 1'b0, 1'b1);
      check("t1_ready_hdr", {31'b0, in_ready}, 1);
      send_byte(8'h00);
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h05);
      check("t1_wr_en",   {31'b0, wr_en},   1);
      check("t1_wr_addr", {24'b0, wr_addr}, 0);
      check("t1_wr_data", {12'b0, wr_data}, 32'h51234);
      check("t1_ready",   {31'b0, in_ready}, 0);
      exp_q.push_back({8'h00, 20'h51234});
      finish_frame();
      check_flags("t1_end", 1'b1, 1'b0, 1'b0);
      check("t1_wr_en_off", {31'b0, wr_en}, 0);
      check_writes("t1");

      // N=2 with in_valid toggling
      pulse_start();
      send_gap(8'h02);
      send_word(20'h00001, 1'b1);
      send_word(20'hABCDE, 1'b1);
      send_word(20'hFFFFF, 1'b1);
      exp_q.push_back({8'h00, 20'h00001});
      exp_q.push_back({8'h01, 20'hABCDE});
      exp_q.push_back({8'h02, 20'hFFFFF});
      finish_frame();
      check_flags("t2_end", 1'b1, 1'b0, 1'b0);
      check("t2_last_addr", {24'b0, wr_addr}, 2);
      check_writes("t2");

      // bad pad nibble in B2
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h15);
      check_flags("t3_err", 1'b0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_writes("t3");

      // reset after B1 of word 3 in an N=7 frame
      pulse_start();
      send_byte(8'h07);
      send_word(20'h11111, 1'b0);
      send_word(20'h22222, 1'b0);
      send_word(20'h33333, 1'b0);
      send_byte(8'h44);
      send_byte(8'h44);
      exp_q.push_back({8'h00, 20'h11111});
      exp_q.push_back({8'h01, 20'h22222});
      exp_q.push_back({8'h02, 20'h33333});
      rst_n = 1'b0;
      #1;
      check_idle("t4_rst");
      check("t4_state", 32'(dut.state), 32'(IDLE));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_writes("t4_pre");
      pulse_start();
      send_byte(8'h00);
      send_word(20'h00AB9, 1'b0);
      exp_q.push_back({8'h00, 20'h00AB9});
      finish_frame();
      check_flags("t4_end", 1'b1, 1'b0, 1'b0);
      check_writes("t4");

      // N=FF full frame with ignored start pulses
      pulse_start();
      send_byte(8'hFF);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         logic [19:0] w;
         v = 8'(i);
         w = {v[3:0], ~v, v};
         if (i == 100 || i == 255) start = 1'b1;
         send_word(w, 1'b0);
         start = 1'b0;
         exp_q.push_back({v, w});
      end
      check("t5_busy_last", {31'b0, busy}, 1);
      finish_frame();
      check_flags("t5_end", 1'b1, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("t5_final_addr", {24'b0, wr_addr}, 32'hFF);
      check_writes("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum trailers 23 (good) and 24 (bad)
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h05);
      exp_q.push_back({8'h00, 20'h51234});
      check("c1_ready_wait", {31'b0, in_ready}, 0);
      send_byte(8'h23);
      check_flags("c1_end", 1'b1, 1'b0, 1'b0);
      check_writes("c1");
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h05);
      exp_q.push_back({8'h00, 20'h51234});
      send_byte(8'h24);
      check_flags("c2_end", 1'b0, 1'b1, 1'b0);
      check_writes("c2");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
